// File: rtl/voting_machine.sv
// Three-candidate ballot counter: synchronized, edge-detected buttons feed
// saturating tallies that stay hidden until the poll is closed.
`default_nettype none

module voting_machine #(
  parameter int COUNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_candidate_1,
  input  logic               i_candidate_2,
  input  logic               i_candidate_3,
  input  logic               i_voting_over,
  output logic [COUNT_W-1:0] o_count1,
  output logic [COUNT_W-1:0] o_count2,
  output logic [COUNT_W-1:0] o_count3
);

  typedef enum logic {
    OPEN   = 1'b0,
    CLOSED = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] TALLY_MAX = '1;
  localparam logic [COUNT_W-1:0] TALLY_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t                       state_reg;
  logic [2:0]                   cand_meta_reg;
  logic [2:0]                   cand_sync_reg;
  logic [2:0]                   cand_prev_reg;
  logic                         over_meta_reg;
  logic                         over_sync_reg;
  logic [2:0]                   press;
  logic                         single_press;
  logic                         vote_en;
  logic [2:0][COUNT_W-1:0]      count_bus;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_meta_reg <= '0;
      cand_sync_reg <= '0;
      cand_prev_reg <= '0;
      over_meta_reg <= 1'b0;
      over_sync_reg <= 1'b0;
    end else begin
      cand_meta_reg <= {i_candidate_3, i_candidate_2, i_candidate_1};
      cand_sync_reg <= cand_meta_reg;
      cand_prev_reg <= cand_sync_reg;
      over_meta_reg <= i_voting_over;
      over_sync_reg <= over_meta_reg;
    end
  end

  assign press        = cand_sync_reg & ~cand_prev_reg;
  assign single_press = (press == 3'b001) || (press == 3'b010) || (press == 3'b100);
  // A press landing in the closing cycle is dropped along with later ones.
  assign vote_en      = (state_reg == OPEN) && !over_sync_reg && single_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= OPEN;
    end else begin
      case (state_reg)
        OPEN:    if (over_sync_reg) state_reg <= CLOSED;
        CLOSED:  state_reg <= CLOSED;
        default: state_reg <= OPEN;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cand
      logic [COUNT_W-1:0] tally_reg;
      logic [COUNT_W-1:0] count_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tally_reg <= '0;
          count_reg <= '0;
        end else begin
          if (vote_en && press[gi] && (tally_reg != TALLY_MAX)) begin
            tally_reg <= tally_reg + TALLY_ONE;
          end
          count_reg <= (state_reg == CLOSED) ? tally_reg : '0;
        end
      end

      assign count_bus[gi] = count_reg;
    end
  endgenerate

  assign o_count1 = count_bus[0];
  assign o_count2 = count_bus[1];
  assign o_count3 = count_bus[2];

endmodule

`default_nettype wire

// File: tb/tb_voting_machine.sv
// Directed bench for voting_machine: table of ballot scenarios plus
// hand-written sequences for latency, lockout and asynchronous reset.
`timescale 1ns/1ps

module tb_voting_machine;

  localparam int COUNT_W = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i_candidate_1 = 1'b0;
  logic               i_candidate_2 = 1'b0;
  logic               i_candidate_3 = 1'b0;
  logic               i_voting_over = 1'b0;
  logic [COUNT_W-1:0] o_count1;
  logic [COUNT_W-1:0] o_count2;
  logic [COUNT_W-1:0] o_count3;

  int checks   = 0;
  int failures = 0;

  voting_machine #(.COUNT_W(COUNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_candidate_1 (i_candidate_1),
    .i_candidate_2 (i_candidate_2),
    .i_candidate_3 (i_candidate_3),
    .i_voting_over (i_voting_over),
    .o_count1      (o_count1),
    .o_count2      (o_count2),
    .o_count3      (o_count3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]         pattern;
    int                 hold;
    int                 reps;
    logic [COUNT_W-1:0] e1;
    logic [COUNT_W-1:0] e2;
    logic [COUNT_W-1:0] e3;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [COUNT_W-1:0] act,
                       input logic [COUNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [COUNT_W-1:0] e1,
                            input logic [COUNT_W-1:0] e2, input logic [COUNT_W-1:0] e3);
    check({name, ".c1"}, o_count1, e1);
    check({name, ".c2"}, o_count2, e2);
    check({name, ".c3"}, o_count3, e3);
  endtask

  task automatic drive(input logic [2:0] mask);
    {i_candidate_3, i_candidate_2, i_candidate_1} = mask;
  endtask

  // Called at a negedge; returns at a negedge with rst released.
  task automatic do_reset();
    drive(3'b000);
    i_voting_over = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Press pattern for hold cycles, then idle gap cycles; optionally verify concealment.
  task automatic vote(input logic [2:0] mask, input int hold, input int gap, input bit conceal);
    drive(mask);
    repeat (hold) begin
      @(negedge clk);
      if (conceal) check_outs("conceal", '0, '0, '0);
    end
    drive(3'b000);
    repeat (gap) begin
      @(negedge clk);
      if (conceal) check_outs("conceal", '0, '0, '0);
    end
  endtask

  // Over sampled at edge M: outputs still 0 after M+2, tallies visible after M+3.
  task automatic close_and_check(input string name, input logic [COUNT_W-1:0] e1,
                                 input logic [COUNT_W-1:0] e2, input logic [COUNT_W-1:0] e3,
                                 input int stable);
    i_voting_over = 1'b1;
    repeat (3) @(negedge clk);
    check_outs({name, ".pre"}, '0, '0, '0);
    @(negedge clk);
    check_outs(name, e1, e2, e3);
    repeat (stable) begin
      @(negedge clk);
      check_outs({name, ".hold"}, e1, e2, e3);
    end
  endtask

  initial begin
    vecs[0] = '{pattern: 3'b001, hold: 1,  reps: 1,  e1: 6'd1, e2: 6'd0, e3: 6'd0};
    vecs[1] = '{pattern: 3'b001, hold: 20, reps: 1,  e1: 6'd1, e2: 6'd0, e3: 6'd0};
    vecs[2] = '{pattern: 3'b011, hold: 1,  reps: 1,  e1: 6'd0, e2: 6'd0, e3: 6'd0};
    vecs[3] = '{pattern: 3'b111, hold: 2,  reps: 3,  e1: 6'd0, e2: 6'd0, e3: 6'd0};
    vecs[4] = '{pattern: 3'b010, hold: 1,  reps: 5,  e1: 6'd0, e2: 6'd5, e3: 6'd0};
    vecs[5] = '{pattern: 3'b100, hold: 1,  reps: 70, e1: 6'd0, e2: 6'd0, e3: 6'd63};
    vecs[6] = '{pattern: 3'b101, hold: 3,  reps: 2,  e1: 6'd0, e2: 6'd0, e3: 6'd0};
    vecs[7] = '{pattern: 3'b000, hold: 1,  reps: 4,  e1: 6'd0, e2: 6'd0, e3: 6'd0};

    // Reset held with buttons toggling
    @(negedge clk);
    drive(3'b101);
    @(negedge clk);
    check_outs("rst_toggle_a", '0, '0, '0);
    drive(3'b010);
    @(negedge clk);
    check_outs("rst_toggle_b", '0, '0, '0);
    drive(3'b000);
    rst = 1'b1;
    @(negedge clk);
    close_and_check("rst_novote", '0, '0, '0, 0);
    $display("seq reset_no_vote c1=%0d c2=%0d c3=%0d", o_count1, o_count2, o_count3);

    // Table-driven scenarios, each in a fresh session
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int r = 0; r < vecs[v].reps; r++) vote(vecs[v].pattern, vecs[v].hold, 3, 1'b0);
      close_and_check($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e2, vecs[v].e3, 0);
      $display("vec %0d pattern=%b hold=%0d reps=%0d -> c1=%0d c2=%0d c3=%0d",
               v, vecs[v].pattern, vecs[v].hold, vecs[v].reps, o_count1, o_count2, o_count3);
    end

    // Basic tally with concealment, then lockout and voting_over drop
    do_reset();
    vote(3'b001, 1, 2, 1'b1);
    vote(3'b010, 1, 2, 1'b1);
    vote(3'b001, 1, 2, 1'b1);
    vote(3'b100, 1, 2, 1'b1);
    vote(3'b010, 1, 2, 1'b1);
    vote(3'b010, 1, 2, 1'b1);
    vote(3'b001, 1, 2, 1'b1);
    vote(3'b100, 1, 2, 1'b1);
    close_and_check("basic", 6'd3, 6'd3, 6'd2, 5);
    $display("seq basic c1=%0d c2=%0d c3=%0d", o_count1, o_count2, o_count3);
    vote(3'b001, 1, 3, 1'b0);
    vote(3'b010, 1, 3, 1'b0);
    vote(3'b100, 1, 3, 1'b0);
    check_outs("lockout", 6'd3, 6'd3, 6'd2);
    i_voting_over = 1'b0;
    vote(3'b001, 1, 4, 1'b0);
    check_outs("over_drop", 6'd3, 6'd3, 6'd2);
    $display("seq lockout c1=%0d c2=%0d c3=%0d", o_count1, o_count2, o_count3);

    // c2 sampled one edge before close counts; c1 sampled with close is dropped
    do_reset();
    drive(3'b010);
    @(negedge clk);
    drive(3'b001);
    i_voting_over = 1'b1;
    @(negedge clk);
    drive(3'b000);
    repeat (4) @(negedge clk);
    check_outs("close_edge", 6'd0, 6'd1, 6'd0);
    $display("seq close_edge c1=%0d c2=%0d c3=%0d", o_count1, o_count2, o_count3);

    // Asynchronous reset between clock edges, then revote from zero
    #2 rst = 1'b0;
    #1 check_outs("async_rst", '0, '0, '0);
    i_voting_over = 1'b0;
    @(negedge clk);
    check_outs("async_rst_hold", '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    vote(3'b100, 1, 3, 1'b1);
    close_and_check("revote", 6'd0, 6'd0, 6'd1, 0);
    $display("seq async_reset_revote c1=%0d c2=%0d c3=%0d", o_count1, o_count2, o_count3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
